// File: rtl/regfile_pkg.sv
// Shared types, default sizing and flat-bus slicing helpers for the GPR file.
package regfile_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREG_DEF  = 32;
    localparam int NRD_DEF   = 2;
    localparam int NFWD_DEF  = 2;
    localparam int CNT_W_DEF = 2;
    localparam int AW_DEF    = $clog2(NREG_DEF);

    typedef logic [XLEN_DEF-1:0]  xlen_t;
    typedef logic [AW_DEF-1:0]    regidx_t;
    typedef logic [CNT_W_DEF-1:0] sbcnt_t;

    // Low bit of element idx in a flat bus of width-bit elements.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters, issue back-pressure and per-port pending lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic              iss_full,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_pend
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             wb_hits_iss;

    assign wb_hits_iss = wb_en && (wb_addr == iss_rd);

    // A saturated destination can only take a new issue if a commit frees a slot this cycle.
    assign iss_full = reset_n && iss_valid && (cnt_q[iss_rd] == CNT_MAX) && !wb_hits_iss;

    // Next counter values: flush wins, otherwise +issue -commit; a commit on an empty counter is a stale drain.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            logic inc;
            logic dec;
            inc = iss_valid && (iss_rd == AW'(r)) && !iss_full && !flush
                  && !((ZERO_REG != 0) && (r == 0));
            dec = wb_en && (wb_addr == AW'(r)) && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    // Counter state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Pending means writes remain after discounting a same-cycle commit to that register.
    for (genvar p = 0; p < NRD; p++) begin : g_pend
        logic [AW-1:0] addr;
        logic          wb_hit;
        assign addr   = rd_addr[slice_lo(p, AW) +: AW];
        assign wb_hit = wb_en && (wb_addr == addr);
        assign rd_pend[p] = wb_hit ? (cnt_q[addr] > CNT_ONE) : (cnt_q[addr] != '0);
    end

endmodule

// File: rtl/regfile_sb.sv
// GPR array with priority bypass (forward sources, then writeback) and a pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int NFWD     = NFWD_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    output logic                 any_busy,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    output logic                 iss_full,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*AW-1:0]   fwd_addr,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 wb_en,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush
);

    logic [XLEN-1:0] gpr_q [NREG];
    logic [NRD-1:0]  rd_pend;
    logic            wb_writes;

    regfile_scoreboard #(
        .NREG     (NREG),
        .NRD      (NRD),
        .CNT_W    (CNT_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clock     (clock),
        .reset_n   (reset_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_full  (iss_full),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .flush     (flush),
        .rd_addr   (rd_addr),
        .rd_pend   (rd_pend)
    );

    // Commits land even during a flush; flush only forgets pending bookkeeping.
    assign wb_writes = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));

    // Storage array.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                gpr_q[r] <= '0;
            end
        end else if (wb_writes) begin
            gpr_q[wb_addr] <= wb_data;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;
        logic            busy;
        logic            fwd_hit;
        logic            fwd_rdy;

        assign addr = rd_addr[slice_lo(p, AW) +: AW];

        // Bypass priority: zero register, youngest matching forward, writeback, array.
        always_comb begin
            val     = gpr_q[addr];
            busy    = rd_pend[p];
            fwd_hit = 1'b0;
            fwd_rdy = 1'b0;
            if (wb_en && (wb_addr == addr)) begin
                val = wb_data;
            end
            // Walk oldest to youngest so the lowest index overrides.
            for (int i = NFWD - 1; i >= 0; i--) begin
                if (fwd_valid[i] && (fwd_addr[slice_lo(i, AW) +: AW] == addr)) begin
                    fwd_hit = 1'b1;
                    fwd_rdy = fwd_ready[i];
                    val     = fwd_data[slice_lo(i, XLEN) +: XLEN];
                end
            end
            if (fwd_hit) begin
                busy = !fwd_rdy;
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                val  = '0;
                busy = 1'b0;
            end
        end

        assign rd_data[slice_lo(p, XLEN) +: XLEN] = val;
        // Busy is held low while in reset regardless of forward inputs.
        assign rd_busy[p] = reset_n && rd_en[p] && busy;
    end

    assign any_busy = |rd_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-driven bench for regfile_sb: expectations are queued with stimulus and drained when outputs settle.
module tb_regfile_sb;

    localparam int XLEN  = 64;
    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NFWD  = 2;
    localparam int CNT_W = 2;

    localparam int K_DATA = 0;
    localparam int K_BUSY = 1;
    localparam int K_ANY  = 2;
    localparam int K_FULL = 3;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [NRD-1:0]       rd_en;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 any_busy;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic                 iss_full;
    logic [NFWD-1:0]      fwd_valid;
    logic [NFWD-1:0]      fwd_ready;
    logic [NFWD*AW-1:0]   fwd_addr;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 wb_en;
    logic [AW-1:0]        wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic                 flush;

    always #5 clock = ~clock;

    regfile_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NFWD(NFWD), .CNT_W(CNT_W), .ZERO_REG(1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .any_busy  (any_busy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_full  (iss_full),
        .fwd_valid (fwd_valid),
        .fwd_ready (fwd_ready),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flush     (flush)
    );

    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [63:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int kind, input int port);
        case (kind)
            K_DATA:  return rd_data[port*XLEN +: XLEN];
            K_BUSY:  return {63'd0, rd_busy[port]};
            K_ANY:   return {63'd0, any_busy};
            default: return {63'd0, iss_full};
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input int port, input logic [63:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.port = port;
        e.val  = v;
        sbq.push_back(e);
    endtask

    task automatic exp_rd(input string tag, input int port, input logic [63:0] d, input logic b);
        push({tag, "_data"}, K_DATA, port, d);
        push({tag, "_busy"}, K_BUSY, port, {63'd0, b});
    endtask

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e.tag, observe(e.kind, e.port), e.val);
        end
    endtask

    task automatic idle();
        rd_en     = '0;
        rd_addr   = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        fwd_valid = '0;
        fwd_ready = '0;
        fwd_addr  = '0;
        fwd_data  = '0;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        flush     = 1'b0;
    endtask

    task automatic rd(input int p, input int a);
        rd_en[p]               = 1'b1;
        rd_addr[p*AW +: AW]    = AW'(a);
    endtask

    task automatic fwd(input int i, input int a, input logic rdy, input logic [63:0] d);
        fwd_valid[i]           = 1'b1;
        fwd_ready[i]           = rdy;
        fwd_addr[i*AW +: AW]   = AW'(a);
        fwd_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic wb(input int a, input logic [63:0] d);
        wb_en   = 1'b1;
        wb_addr = AW'(a);
        wb_data = d;
    endtask

    task automatic iss(input int a);
        iss_valid = 1'b1;
        iss_rd    = AW'(a);
    endtask

    // Inputs are driven just after the falling edge; outputs are sampled 2ns later, well before the rising edge.
    task automatic cycle_end();
        #2;
        drain();
        @(negedge clock);
        idle();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();

        // During reset: busy gated off, bypass still visible.
        fwd(0, 5, 1'b0, 64'h55);
        rd(0, 5);
        iss(1);
        exp_rd("rst_fwd", 0, 64'h55, 1'b0);
        push("rst_any", K_ANY, 0, 64'd0);
        push("rst_full", K_FULL, 0, 64'd0);
        cycle_end();
        reset_n = 1'b1;

        // 1: reset contents and zero register.
        rd(0, 5); rd(1, 5);
        exp_rd("t1_p0", 0, 64'd0, 1'b0);
        exp_rd("t1_p1", 1, 64'd0, 1'b0);
        push("t1_any", K_ANY, 0, 64'd0);
        cycle_end();
        wb(0, 64'hDEAD); rd(0, 0);
        exp_rd("t1_x0_wb", 0, 64'd0, 1'b0);
        cycle_end();
        rd(0, 0);
        exp_rd("t1_x0_after", 0, 64'd0, 1'b0);
        cycle_end();

        // 2: single in-flight write resolved by forward then commit.
        iss(3);
        push("t2_iss", K_FULL, 0, 64'd0);
        cycle_end();
        rd(0, 3); fwd(0, 3, 1'b0, 64'h0);
        push("t2_busy", K_BUSY, 0, 64'd1);
        push("t2_any", K_ANY, 0, 64'd1);
        cycle_end();
        rd(0, 3); fwd(0, 3, 1'b1, 64'h11);
        exp_rd("t2_fwd_rdy", 0, 64'h11, 1'b0);
        cycle_end();
        rd(0, 3); fwd(0, 3, 1'b1, 64'h11); fwd(1, 3, 1'b0, 64'h22);
        exp_rd("t2_youngest", 0, 64'h11, 1'b0);
        cycle_end();
        rd(0, 3); fwd(0, 3, 1'b0, 64'h33); fwd(1, 3, 1'b1, 64'h22);
        exp_rd("t2_young_unrdy", 0, 64'h33, 1'b1);
        cycle_end();
        rd(0, 3); wb(3, 64'h11);
        exp_rd("t2_wb", 0, 64'h11, 1'b0);
        cycle_end();
        rd(0, 3);
        exp_rd("t2_array", 0, 64'h11, 1'b0);
        cycle_end();

        // 3: two in-flight writes to x7.
        iss(7);
        cycle_end();
        iss(7);
        cycle_end();
        rd(1, 7); rd(0, 3);
        push("t3_busy2", K_BUSY, 1, 64'd1);
        exp_rd("t3_other", 0, 64'h11, 1'b0);
        cycle_end();
        rd(1, 7); wb(7, 64'hA);
        exp_rd("t3_wb1", 1, 64'hA, 1'b1);
        cycle_end();
        rd(1, 7); wb(7, 64'hB);
        exp_rd("t3_wb2", 1, 64'hB, 1'b0);
        cycle_end();
        rd(1, 7);
        exp_rd("t3_done", 1, 64'hB, 1'b0);
        cycle_end();
        rd_addr[AW +: AW] = AW'(7);
        push("t3_rd_en_off", K_BUSY, 1, 64'd0);
        cycle_end();

        // 4: saturation of x9.
        for (int k = 0; k < 3; k++) begin
            iss(9);
            push("t4_fill", K_FULL, 0, 64'd0);
            cycle_end();
        end
        iss(9);
        push("t4_full", K_FULL, 0, 64'd1);
        cycle_end();
        iss(9); wb(9, 64'h99);
        push("t4_full_wb", K_FULL, 0, 64'd0);
        cycle_end();
        iss(9);
        push("t4_still_full", K_FULL, 0, 64'd1);
        cycle_end();
        rd(1, 9);
        exp_rd("t4_rd", 1, 64'h99, 1'b1);
        cycle_end();

        // 5: flush with a simultaneous issue, then a stale commit.
        iss(4);
        cycle_end();
        iss(4);
        cycle_end();
        rd(0, 4);
        push("t5_pre", K_BUSY, 0, 64'd1);
        cycle_end();
        iss(4); flush = 1'b1;
        push("t5_flush_full", K_FULL, 0, 64'd0);
        cycle_end();
        rd(0, 4); rd(1, 9);
        push("t5_x4_clear", K_BUSY, 0, 64'd0);
        push("t5_x9_clear", K_BUSY, 1, 64'd0);
        cycle_end();
        rd(0, 4); wb(4, 64'h44);
        exp_rd("t5_stale_wb", 0, 64'h44, 1'b0);
        cycle_end();
        rd(0, 4);
        exp_rd("t5_no_underflow", 0, 64'h44, 1'b0);
        cycle_end();

        // 6: asynchronous reset mid-cycle with a pending counter.
        iss(12);
        cycle_end();
        rd(0, 12); rd(1, 3);
        push("t6_pre", K_BUSY, 0, 64'd1);
        exp_rd("t6_pre_x3", 1, 64'h11, 1'b0);
        #2;
        drain();
        #1;
        reset_n = 1'b0;
        #1;
        push("t6_busy", K_BUSY, 0, 64'd0);
        push("t6_any", K_ANY, 0, 64'd0);
        exp_rd("t6_x3_rst", 1, 64'd0, 1'b0);
        drain();
        @(negedge clock);
        idle();
        @(negedge clock);
        reset_n = 1'b1;
        rd(0, 3); rd(1, 7);
        exp_rd("t6_x3_post", 0, 64'd0, 1'b0);
        exp_rd("t6_x7_post", 1, 64'd0, 1'b0);
        cycle_end();
        rd(0, 12);
        exp_rd("t6_x12_post", 0, 64'd0, 1'b0);
        cycle_end();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
